// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - per-LED PWM fade stage between the pattern counter and the LED pins
//
// Ramps each LED's brightness toward its target endpoint in fixed steps and
// drives the pins through a shared PWM counter.
//
// Ports
//   CLK_24MHZ      in   1        system clock
//   RESET_N        in   1        asynchronous active-low reset
//   pattern        in   NUM_LED  target pattern, 1 = LED on
//   pattern_valid  in   1        strobe: latch pattern as the new target
//   busy           out  1        registered: some LED level is not at its endpoint
//   USER_LED       out  NUM_LED  registered pin drive, polarity set by ACTIVE_LOW

module led_fade_driver #(
    parameter int NUM_LED    = 8,
    parameter int PWM_BITS   = 8,
    parameter int STEP_DIV   = 23529,
    parameter int STEP_SIZE  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                CLK_24MHZ,
    input  logic                RESET_N,
    input  logic [NUM_LED-1:0]  pattern,
    input  logic                pattern_valid,
    output logic                busy,
    output logic [NUM_LED-1:0]  USER_LED
);

    localparam int MAX  = (1 << PWM_BITS) - 1;
    localparam int SC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(MAX - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = PWM_BITS'(MAX);
    localparam logic [PWM_BITS:0]   MAX_X     = (PWM_BITS + 1)'(MAX);
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP_SIZE);
    localparam logic [NUM_LED-1:0]  LED_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_LED-1:0]  r_target;
    logic [PWM_BITS-1:0] r_level [NUM_LED];
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [SC_W-1:0]     r_step_cnt;

    logic                w_step_tick;
    logic [NUM_LED-1:0]  w_target_nxt;
    logic [PWM_BITS-1:0] w_level_nxt [NUM_LED];
    logic [NUM_LED-1:0]  w_off_end;
    logic [NUM_LED-1:0]  w_lit;

    assign w_step_tick  = (r_step_cnt == STEP_LAST);
    assign w_target_nxt = pattern_valid ? pattern : r_target;

    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
        logic [PWM_BITS:0]   w_up;
        logic [PWM_BITS:0]   w_dn;
        logic [PWM_BITS-1:0] w_up_sat;
        logic [PWM_BITS-1:0] w_dn_sat;

        // One extra bit catches overflow past MAX and borrow below zero.
        assign w_up     = {1'b0, r_level[gi]} + STEP_X;
        assign w_dn     = {1'b0, r_level[gi]} - STEP_X;
        assign w_up_sat = (w_up > MAX_X) ? LVL_MAX : w_up[PWM_BITS-1:0];
        assign w_dn_sat = w_dn[PWM_BITS] ? '0 : w_dn[PWM_BITS-1:0];

        // The step always uses the registered target, so a new pattern
        // arriving on a tick cycle only steers the following tick.
        assign w_level_nxt[gi] = !w_step_tick  ? r_level[gi] :
                                 r_target[gi]  ? w_up_sat    : w_dn_sat;

        assign w_off_end[gi] = (w_level_nxt[gi] != (w_target_nxt[gi] ? LVL_MAX : '0));
        assign w_lit[gi]     = (r_level[gi] > r_pwm_cnt);
    end

    always_ff @(posedge CLK_24MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            r_target   <= '0;
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
            busy       <= 1'b0;
            USER_LED   <= LED_OFF;
            for (int i = 0; i < NUM_LED; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_target   <= w_target_nxt;
            r_pwm_cnt  <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
            r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
            busy       <= |w_off_end;
            USER_LED   <= (ACTIVE_LOW != 0) ? ~w_lit : w_lit;
            for (int i = 0; i < NUM_LED; i++) begin
                r_level[i] <= w_level_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - directed self-checking bench for led_fade_driver

module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pat = 8'h00;
    logic       pat_v = 1'b0;
    logic       busy;
    logic [7:0] led;
    logic [7:0] pat2 = 8'h00;
    logic       pat2_v = 1'b0;
    logic       busy2;
    logic [7:0] led2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_fade_driver #(
        .NUM_LED(8), .PWM_BITS(4), .STEP_DIV(4), .STEP_SIZE(4), .ACTIVE_LOW(1)
    ) dut (
        .CLK_24MHZ(clk), .RESET_N(rst_n), .pattern(pat), .pattern_valid(pat_v),
        .busy(busy), .USER_LED(led)
    );

    // Slow-stepping copy so a level holds long enough for a full PWM period.
    led_fade_driver #(
        .NUM_LED(8), .PWM_BITS(4), .STEP_DIV(1000), .STEP_SIZE(4), .ACTIVE_LOW(1)
    ) dut2 (
        .CLK_24MHZ(clk), .RESET_N(rst_n), .pattern(pat2), .pattern_valid(pat2_v),
        .busy(busy2), .USER_LED(led2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pat    = 8'h00;
        pat_v  = 1'b0;
        pat2   = 8'h00;
        pat2_v = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] p);
        pat   = p;
        pat_v = 1'b1;
        tick();
        pat_v = 1'b0;
    endtask

    task automatic wait_lvl(input logic [3:0] lvl, input int bound, input string tag);
        int n;
        n = 0;
        while (dut.r_level[0] != lvl && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(dut.r_level[0]), 32'(lvl));
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] seq [4];
        int         tstamp [4];
        int         idx;
        int         bad;
        int         zeros;
        bit         saw12;

        // 1: reset state, then idle after release
        repeat (3) tick();
        chk("rst_led", 32'(led), 32'hFF);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (led !== 8'hFF || busy !== 1'b0) bad++;
        end
        chk("idle_100", 32'(bad), 32'h0);

        // 2: fade-in 4,8,12,15 every 4 cycles, then fully lit
        do_reset();
        load(8'h01);
        prev = 4'd0;
        idx  = 0;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            tick();
            if (dut.r_level[0] != prev) begin
                prev        = dut.r_level[0];
                seq[idx]    = prev;
                tstamp[idx] = c;
                if (prev == 4'd12) chk("busy_at12", 32'(busy), 32'h1);
                if (prev == 4'd4)  chk("busy_at4", 32'(busy), 32'h1);
                idx++;
            end
        end
        chk("fade_steps", 32'(idx), 32'd4);
        chk("fade_l0", 32'(seq[0]), 32'd4);
        chk("fade_l1", 32'(seq[1]), 32'd8);
        chk("fade_l2", 32'(seq[2]), 32'd12);
        chk("fade_l3", 32'(seq[3]), 32'd15);
        chk("fade_gap1", 32'(tstamp[1] - tstamp[0]), 32'd4);
        chk("fade_gap3", 32'(tstamp[3] - tstamp[2]), 32'd4);
        tick();
        chk("busy_done", 32'(busy), 32'h0);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (led !== 8'hFE) bad++;
        end
        chk("full_on", 32'(bad), 32'h0);

        // 4: reversal at level 8 -> 4, 0, never 12
        do_reset();
        load(8'h01);
        wait_lvl(4'd8, 40, "rev_reach8");
        load(8'h00);
        prev  = 4'd8;
        idx   = 0;
        saw12 = 1'b0;
        for (int c = 0; c < 30 && idx < 2; c++) begin
            tick();
            if (dut.r_level[0] == 4'd12) saw12 = 1'b1;
            if (dut.r_level[0] != prev) begin
                prev     = dut.r_level[0];
                seq[idx] = prev;
                idx++;
            end
        end
        chk("rev_steps", 32'(idx), 32'd2);
        chk("rev_l0", 32'(seq[0]), 32'd4);
        chk("rev_l1", 32'(seq[1]), 32'd0);
        chk("rev_no12", 32'(saw12), 32'h0);
        tick();
        chk("rev_busy", 32'(busy), 32'h0);
        chk("rev_led", 32'(led), 32'hFF);

        // 5: new pattern on the tick cycle uses the old target for that tick
        do_reset();
        bad = 0;
        while (dut.r_step_cnt != 2'd3 && bad < 10) begin
            tick();
            bad++;
        end
        chk("col_align", 32'(dut.r_step_cnt), 32'd3);
        load(8'h01);
        chk("col_hold", 32'(dut.r_level[0]), 32'd0);
        repeat (4) tick();
        chk("col_next", 32'(dut.r_level[0]), 32'd4);

        // 6: asynchronous reset between edges at level 12
        do_reset();
        load(8'h01);
        wait_lvl(4'd12, 40, "ar_reach12");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_led", 32'(led), 32'hFF);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_level", 32'(dut.r_level[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 3: duty at level 8 is 8 of 15 cycles, other pins stay dark
        do_reset();
        pat2   = 8'h01;
        pat2_v = 1'b1;
        tick();
        pat2_v = 1'b0;
        bad = 0;
        while (dut2.r_level[0] != 4'd8 && bad < 2500) begin
            tick();
            bad++;
        end
        chk("duty_reach8", 32'(dut2.r_level[0]), 32'd8);
        tick();
        tick();
        zeros = 0;
        bad   = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (led2[0] == 1'b0) zeros++;
            if (led2[7:1] !== 7'h7F) bad++;
        end
        chk("duty_on", 32'(zeros), 32'd8);
        chk("duty_others", 32'(bad), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
